// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM encoding and
// baud-counter sizing helpers (also intended for a future transmitter).
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    localparam int unsigned ST_W = 3;
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PAR       = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    // Clocks per bit time.
    function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                                 input int unsigned bps);
        return clk_freq / bps;
    endfunction

    // Width of a counter running 0..baud_cnt_max-1.
    function automatic int unsigned baud_cnt_width(input int unsigned clk_freq,
                                                   input int unsigned bps);
        return $clog2(baud_cnt_max(clk_freq, bps));
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input synchroniser and falling-edge detector for the UART rx pin.
// Ports:
//   clk, rst_n      - clock, async active-low reset
//   rx_i            - asynchronous serial line, idle high
//   rx_sync_o       - synchronised line (registered)
//   start_nedge_c   - one-cycle high-to-low edge of rx_sync_o (combinational)
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_i,
    output logic rx_sync_o,
    output logic start_nedge_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;

    // All stages reset to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            edge_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_sync_o     = sync_q[SYNC_STAGES-1];
    assign start_nedge_c = edge_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DATA_BITS payload, optional even/odd parity,
// 1 or 2 stop bits, 3-sample majority vote per bit, false-start rejection,
// parity/framing/break reporting.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   rx          - serial input, idle high
//   po_data     - received word (LSB first on the line), holds between frames
//   po_flag     - one-cycle strobe qualifying po_data and the error flags
//   parity_err  - parity mismatch
//   frame_err   - a stop bit sampled low
//   break_det   - all data, parity and first stop bit sampled low
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned UART_BPS    = 115200,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] po_data,
    output logic                 po_flag,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det
);

    localparam int unsigned BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam int unsigned CNT_W        = baud_cnt_width(CLK_FREQ, UART_BPS);
    localparam int unsigned MID          = BAUD_CNT_MAX / 2;
    localparam int unsigned BIT_W        = 4;

    logic rx_sync;
    logic start_nedge;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_i          (rx),
        .rx_sync_o     (rx_sync),
        .start_nedge_c (start_nedge)
    );

    logic [ST_W-1:0]      state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           smp_q, smp_d;
    logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 ones_q, ones_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 brk_q, brk_d;
    logic [DATA_BITS-1:0] po_data_d;
    logic                 po_flag_d, parity_err_d, frame_err_d, break_det_d;

    logic at_mid_m1, at_mid, decide, wrap, bit_c;

    assign at_mid_m1 = (cnt_q == CNT_W'(MID - 1));
    assign at_mid    = (cnt_q == CNT_W'(MID));
    assign decide    = (cnt_q == CNT_W'(MID + 1));
    assign wrap      = (cnt_q == CNT_W'(BAUD_CNT_MAX - 1));
    // Majority of the MID-1 and MID samples plus the live MID+1 sample.
    assign bit_c     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_sync) | (smp_q[1] & rx_sync);

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = wrap ? '0 : cnt_q + CNT_W'(1);
        smp_d        = smp_q;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        ones_d       = ones_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        brk_d        = brk_q;
        po_data_d    = po_data;
        po_flag_d    = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        break_det_d  = 1'b0;

        if (at_mid_m1) smp_d[0] = rx_sync;
        if (at_mid)    smp_d[1] = rx_sync;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start_nedge) begin
                    state_d   = ST_START;
                    bit_idx_d = '0;
                    ones_d    = 1'b0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                    brk_d     = 1'b0;
                end
            end
            ST_START: begin
                if (decide && bit_c) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (wrap) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (decide) begin
                    shreg_d   = {bit_c, shreg_q[DATA_BITS-1:1]};
                    ones_d    = ones_q | bit_c;
                    bit_idx_d = bit_idx_q + BIT_W'(1);
                end
                if (wrap && (bit_idx_q == BIT_W'(DATA_BITS))) begin
                    bit_idx_d = '0;
                    state_d   = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
                end
            end
            ST_PAR: begin
                if (decide) begin
                    ones_d = ones_q | bit_c;
                    perr_d = (PARITY == PARITY_ODD) ? ~(^shreg_q ^ bit_c) : (^shreg_q ^ bit_c);
                end
                if (wrap) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (decide) begin
                    if (bit_idx_q == '0) brk_d = ~ones_q & ~bit_c;
                    if (!bit_c) ferr_d = 1'b1;
                    // Strobe on the last stop decision so back-to-back frames are not lost.
                    if (bit_idx_q == BIT_W'(STOP_BITS - 1)) begin
                        po_flag_d    = 1'b1;
                        po_data_d    = shreg_q;
                        parity_err_d = perr_q;
                        frame_err_d  = ferr_q | ~bit_c;
                        break_det_d  = (bit_idx_q == '0) ? (~ones_q & ~bit_c) : brk_q;
                        state_d      = bit_c ? ST_IDLE : ST_WAIT_IDLE;
                        cnt_d        = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                    end
                end
            end
            ST_WAIT_IDLE: begin
                // Only re-arm once the line is back high.
                if (rx_sync) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            smp_q      <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            ones_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
            po_data    <= '0;
            po_flag    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            smp_q      <= smp_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            ones_q     <= ones_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
            po_data    <= po_data_d;
            po_flag    <= po_flag_d;
            parity_err <= parity_err_d;
            frame_err  <= frame_err_d;
            break_det  <= break_det_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 7E1 and 8N2 instances on one clock.
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int BIT = 434;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
    logic [7:0] d_a, d_c;
    logic [6:0] d_b;
    logic f_a, pe_a, fe_a, bk_a;
    logic f_b, pe_b, fe_b, bk_b;
    logic f_c, pe_c, fe_c, bk_c;

    uart_rx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .po_data(d_a), .po_flag(f_a),
        .parity_err(pe_a), .frame_err(fe_a), .break_det(bk_a));
    uart_rx_cfg #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_7e1 (
        .clk(clk), .rst_n(rst_n), .rx(rx_b), .po_data(d_b), .po_flag(f_b),
        .parity_err(pe_b), .frame_err(fe_b), .break_det(bk_b));
    uart_rx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .rst_n(rst_n), .rx(rx_c), .po_data(d_c), .po_flag(f_c),
        .parity_err(pe_c), .frame_err(fe_c), .break_det(bk_c));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int flag_cyc_a = 0;
    int wide_cnt = 0;
    int t_fall;
    logic p_a = 1'b0, p_b = 1'b0, p_c = 1'b0;
    // Captured strobes: {break, frame, parity, data[8:0]}
    logic [11:0] q_a[$], q_b[$], q_c[$];

    // Strobe monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        p_a <= f_a;
        p_b <= f_b;
        p_c <= f_c;
        if (f_a) begin
            q_a.push_back({bk_a, fe_a, pe_a, 1'b0, d_a});
            flag_cyc_a <= cyc;
        end
        if (f_b) q_b.push_back({bk_b, fe_b, pe_b, 2'b00, d_b});
        if (f_c) q_c.push_back({bk_c, fe_c, pe_c, 1'b0, d_c});
        if ((f_a && p_a) || (f_b && p_b) || (f_c && p_c)) wide_cnt <= wide_cnt + 1;
    end

    initial begin
        repeat (150000) @(negedge clk);
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_rx(input int sel, input logic v);
        case (sel)
            0: rx_a = v;
            1: rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive n line bits LSB first; optionally a one-clock inverted spike
    // that lands exactly on the MID sample of bit spike_bit.
    task automatic send_bits(input int sel, input logic [15:0] bits, input int n, input int spike_bit);
        for (int j = 0; j < n; j++) begin
            set_rx(sel, bits[j]);
            if (j == spike_bit) begin
                wait_clks(218);
                set_rx(sel, ~bits[j]);
                wait_clks(1);
                set_rx(sel, bits[j]);
                wait_clks(BIT - 219);
            end else begin
                wait_clks(BIT);
            end
        end
    endtask

    task automatic expect_frame(input int sel, input string tag, input logic [8:0] d,
                                input logic pe, input logic fe, input logic bk);
        int sz;
        logic [11:0] w;
        case (sel)
            0: sz = q_a.size();
            1: sz = q_b.size();
            default: sz = q_c.size();
        endcase
        checks++;
        assert (sz > 0) else begin
            errors++;
            $error("FAIL %s_present: observed 0 strobes expected 1", tag);
        end
        if (sz > 0) begin
            case (sel)
                0: w = q_a.pop_front();
                1: w = q_b.pop_front();
                default: w = q_c.pop_front();
            endcase
            check(tag, 32'(w), 32'({bk, fe, pe, d}));
        end
    endtask

    initial begin
        // Reset values
        wait_clks(5);
        check("reset_8n1", 32'({d_a, f_a, pe_a, fe_a, bk_a}), 32'h0);
        check("reset_7e1", 32'({d_b, f_b, pe_b, fe_b, bk_b}), 32'h0);
        check("reset_8n2", 32'({d_c, f_c, pe_c, fe_c, bk_c}), 32'h0);
        rst_n = 1'b1;
        wait_clks(10);

        // 8N1 back-to-back 0xA5, 0x3C
        t_fall = cyc;
        send_bits(0, 16'({1'b1, 8'hA5, 1'b0}), 10, -1);
        check("t1_latency", 32'(flag_cyc_a - t_fall), 32'd4128);
        send_bits(0, 16'({1'b1, 8'h3C, 1'b0}), 10, -1);
        wait_clks(2 * BIT);
        expect_frame(0, "t1_a5", 9'h0A5, 1'b0, 1'b0, 1'b0);
        expect_frame(0, "t1_3c", 9'h03C, 1'b0, 1'b0, 1'b0);
        check("t1_extra", 32'(q_a.size()), 32'd0);

        // 7E1 0x55: parity bit inverted, then correct (even parity bit = 0)
        send_bits(1, 16'({1'b1, 1'b1, 7'h55, 1'b0}), 10, -1);
        send_bits(1, 16'({1'b1, 1'b0, 7'h55, 1'b0}), 10, -1);
        wait_clks(2 * BIT);
        expect_frame(1, "t2_bad_par", 9'h055, 1'b1, 1'b0, 1'b0);
        expect_frame(1, "t2_good_par", 9'h055, 1'b0, 1'b0, 1'b0);
        check("t2_extra", 32'(q_b.size()), 32'd0);

        // 8N2 0x81 with second stop low, idle, then 0x12
        send_bits(2, 16'({1'b0, 1'b1, 8'h81, 1'b0}), 11, -1);
        set_rx(2, 1'b1);
        wait_clks(BIT);
        send_bits(2, 16'({2'b11, 8'h12, 1'b0}), 11, -1);
        wait_clks(2 * BIT);
        expect_frame(2, "t3_stop2_low", 9'h081, 1'b0, 1'b1, 1'b0);
        expect_frame(2, "t3_next", 9'h012, 1'b0, 1'b0, 1'b0);
        check("t3_extra", 32'(q_c.size()), 32'd0);

        // Break: line low for 20 bit times
        set_rx(0, 1'b0);
        wait_clks(20 * BIT);
        check("t4_wait_state", 32'(u_8n1.state_q), 32'(ST_WAIT_IDLE));
        set_rx(0, 1'b1);
        wait_clks(2 * BIT);
        expect_frame(0, "t4_break", 9'h000, 1'b0, 1'b1, 1'b1);
        check("t4_extra", 32'(q_a.size()), 32'd0);

        // 100-clock glitch is a false start
        set_rx(0, 1'b0);
        wait_clks(100);
        set_rx(0, 1'b1);
        wait_clks(1000);
        check("t5_no_flag", 32'(q_a.size()), 32'd0);
        check("t5_idle", 32'(u_8n1.state_q), 32'(ST_IDLE));

        // Spike on the MID sample of data bit 2 (line bit 3) of 0xC3
        send_bits(0, 16'({1'b1, 8'hC3, 1'b0}), 10, 3);
        wait_clks(2 * BIT);
        expect_frame(0, "t5_spike", 9'h0C3, 1'b0, 1'b0, 1'b0);

        // Reset during data bit 4, then a clean 0x5A
        send_bits(0, 16'({4'hC, 1'b0}), 5, -1);
        set_rx(0, 1'b1);
        wait_clks(200);
        rst_n = 1'b0;
        wait_clks(2);
        check("t6_reset_out", 32'({d_a, f_a, pe_a, fe_a, bk_a}), 32'h0);
        check("t6_reset_state", 32'(u_8n1.state_q), 32'(ST_IDLE));
        wait_clks(5);
        rst_n = 1'b1;
        wait_clks(20);
        send_bits(0, 16'({1'b1, 8'h5A, 1'b0}), 10, -1);
        wait_clks(2 * BIT);
        expect_frame(0, "t6_5a", 9'h05A, 1'b0, 1'b0, 1'b0);
        check("t6_extra", 32'(q_a.size()), 32'd0);

        check("flag_width", 32'(wide_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver: configurable data width, parity mode and stop-bit count, with 3-sample majority voting, false-start rejection, and parity/framing/break error reporting. It sits between the board `rx` pin and the command decoder of the smart-car FPGA and replaces the fixed 8N1 receiver wherever error visibility or non-8N1 framing is needed. It outputs one parallel word per frame with a single-cycle valid strobe and coincident error flags.

## Interface
- `CLK_FREQ`, 50_000_000: system clock in Hz.
- `UART_BPS`, 115200: baud rate.
- `DATA_BITS`, 8: payload bits; legal range 5..9.
- `PARITY`, 0: 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1: 1 or 2.
- `SYNC_STAGES`, 2: synchroniser depth; minimum 2.

Ports:
- `clk` in 1: system clock. The block uses one clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `rx` in 1: asynchronous serial input, idle high.
- `po_data` out DATA_BITS: received word, LSB first on the line.
- `po_flag` out 1: one-cycle strobe; `po_data` and the error flags are valid on this cycle.
- `parity_err` out 1: parity mismatch, qualified by `po_flag`.
- `frame_err` out 1: at least one stop bit sampled low, qualified by `po_flag`.
- `break_det` out 1: all data bits, the parity bit (if present) and the first stop bit are 0, qualified by `po_flag`.

## Operation
- `rx` passes through SYNC_STAGES flops, all reset to 1, plus one edge register. A falling edge is a high-to-low transition on the synchronised line.
- BAUD_CNT_MAX = CLK_FREQ/UART_BPS. The counter width is $clog2(BAUD_CNT_MAX). The counter runs 0..BAUD_CNT_MAX-1 in every non-IDLE state, wraps, and is held at 0 in IDLE.
- Each bit is sampled at counts MID-1, MID and MID+1, where MID = BAUD_CNT_MAX/2. The bit value is the majority of the three samples and is decided at count MID+1.
- FSM states: IDLE, START, DATA, PAR, STOP, WAIT_IDLE.
  - IDLE -> START on a falling edge.
  - START: a majority of 1 is a false start; go to IDLE with no strobe. A majority of 0 goes to DATA at the wrap.
  - DATA: shift in LSB first. After DATA_BITS bits go to PAR (PARITY != 0), otherwise to STOP.
  - PAR: compare the sampled bit with even/odd parity of the data; the mismatch is latched internally.
  - STOP: sample each stop bit; a 0 in any stop bit latches the frame error.
  - The strobe fires on the decision of the last stop bit; it does not wait for the stop-bit wrap. Next state is IDLE if the final stop sample is 1, otherwise WAIT_IDLE.
  - WAIT_IDLE -> IDLE once the synchronised line reads 1. A new start edge is never armed while the line is low.
- `po_data` updates on every completed frame, including frames with errors, and holds between frames.
- `break_det` implies `frame_err`.
- Reset mid-frame: FSM goes to IDLE, counters clear, the synchroniser sets to 1, and any partial word is discarded.

## Timing
- Reset values: `po_data` 0, `po_flag` 0, `parity_err` 0, `frame_err` 0, `break_det` 0.
- Falling edge on `rx` to START entry: SYNC_STAGES+1 clocks.
- `po_flag`, `po_data` and the error flags are registered and assert together for exactly one clock, one clock after the last stop-bit decision at count MID+1.
- `po_flag` rate is at most one per frame. Back-to-back frames with no idle gap are received without loss, because the strobe precedes the end of the stop bit.
- A start-bit glitch shorter than roughly BAUD_CNT_MAX/2 clocks is rejected.

## Structure
- Shared package `uart_pkg`:
  - PARITY_NONE/EVEN/ODD localparams.
  - FSM state encoding.
  - A function computing BAUD_CNT_MAX and counter width from CLK_FREQ/UART_BPS, for reuse by a future uart_tx_cfg.
- One sub-module, `uart_rx_sync`: SYNC_STAGES synchroniser plus falling-edge detect. Outputs are the synchronised line and a one-cycle `start_nedge`.

## Test plan
All scenarios use CLK_FREQ 50M and UART_BPS 115200, so BAUD_CNT_MAX = 434 and MID = 217.
- 8N1, send 0xA5, then 0x3C back-to-back with no idle gap -> `po_data` 0xA5 then 0x3C, two single-cycle `po_flag` pulses, all error flags 0.
- DATA_BITS=7, PARITY=1 (even), send 0x55 with the parity bit inverted -> `po_data` 0x55, `parity_err` 1. Resend with correct parity -> `parity_err` 0.
- 8N2, send 0x81 with the second stop bit low -> `frame_err` 1 and `break_det` 0; FSM goes through WAIT_IDLE and the next frame 0x12 is received cleanly.
- Hold `rx` low for 20 bit times -> one `po_flag` with `po_data` 0, `frame_err` 1 and `break_det` 1; no further strobe until `rx` returns high and a new start bit arrives.
- Low glitch of 100 clocks on idle `rx` -> no `po_flag`, FSM back in IDLE. Single-clock spike at sample MID within a data bit -> the majority vote masks it and the data is correct.
- Assert `rst_n` during data bit 4 -> all outputs 0 and the FSM in IDLE. The next full frame 0x5A is received correctly.
